// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type and
// the byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } lsu_state_e;

  // funct3[1:0] encodes access width for both loads and stores.
  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      F3Sb[1:0]: be = 4'b0001 << addr_lo;
      F3Sh[1:0]: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword lane from a read word and sign- or
// zero-extends it according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3Lb:    o_data = {{24{w_byte[7]}}, w_byte};
      F3Lh:    o_data = {{16{w_half[15]}}, w_half};
      F3Lbu:   o_data = {24'd0, w_byte};
      F3Lhu:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one access at a time on a req/ack bus with timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall_o,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  lsu_state_e  r_state, w_state_d;
  logic [31:0] r_addr, r_wdata, r_wb_data, w_load_data, w_st_data;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [1:0]  r_lo, w_lo;
  logic        r_load, r_store, r_err;
  logic [9:0]  r_cnt, w_cnt_inc;
  logic        w_op, w_f3_bad, w_misalign, w_illegal;
  logic        w_accept, w_trap, w_ack, w_timeout;

  assign w_op      = ex_valid & (ex_load | ex_store);
  assign w_f3_bad  = (ex_funct3 == 3'b011) | (ex_funct3[2:1] == 2'b11);
  assign w_cnt_inc = r_cnt + 10'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((ex_funct3[1:0] == F3Sh[1:0]) & ex_addr[0]) |
                      ((ex_funct3[1:0] == F3Sw[1:0]) & (ex_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = w_f3_bad | w_misalign;

  // Natural alignment of the lane offset; only reachable for misaligned
  // accesses when trapping is disabled.
  always_comb begin
    w_lo      = ex_addr[1:0];
    w_st_data = ex_wdata;
    case (ex_funct3[1:0])
      F3Sb[1:0]: begin
        w_lo      = ex_addr[1:0];
        w_st_data = {4{ex_wdata[7:0]}};
      end
      F3Sh[1:0]: begin
        w_lo      = {ex_addr[1], 1'b0};
        w_st_data = {2{ex_wdata[15:0]}};
      end
      default: begin
        w_lo      = 2'b00;
        w_st_data = ex_wdata;
      end
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_trap    = 1'b0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_op) begin
          if (w_illegal) begin
            w_trap    = 1'b1;
            w_state_d = StDone;
          end else begin
            w_accept  = 1'b1;
            w_state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (dm_ack) begin
          w_ack     = 1'b1;
          w_state_d = StDone;
        end else if (w_cnt_inc == TimeoutCnt) begin
          w_timeout = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wb_data <= '0;
      r_be      <= '0;
      r_f3      <= '0;
      r_rd      <= '0;
      r_lo      <= '0;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_addr  <= {ex_addr[31:2], 2'b00};
        r_lo    <= w_lo;
        r_be    <= lsu_be(ex_funct3, w_lo);
        r_wdata <= w_st_data;
        r_f3    <= ex_funct3;
        r_rd    <= ex_rd;
        r_load  <= ex_load;
        r_store <= ex_store;
        r_err   <= 1'b0;
        r_cnt   <= '0;
      end else if (w_trap) begin
        r_rd    <= ex_rd;
        r_load  <= ex_load;
        r_store <= ex_store;
        r_err   <= 1'b1;
      end
      if (r_state == StBusy) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_ack && r_load) begin
        r_wb_data <= w_load_data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  load_align u_load_align (
    .i_rdata   (dm_rdata),
    .i_addr_lo (r_lo),
    .i_funct3  (r_f3),
    .o_data    (w_load_data)
  );

  assign stall_o  = ((r_state == StIdle) & w_op) | (r_state == StBusy);
  assign dm_req   = (r_state == StBusy);
  assign dm_we    = dm_req & r_store;
  assign dm_addr  = r_addr;
  assign dm_be    = r_be;
  assign dm_wdata = r_wdata;
  assign wb_valid = (r_state == StDone) & r_load & ~r_err;
  assign err_o    = (r_state == StDone) & r_err;
  assign wb_rd    = r_rd;
  assign wb_data  = r_wb_data;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the RV32I 5-stage pipeline. It sits in the MEM stage between the EX/MEM pipeline register and the data memory. It accepts one memory operation at a time and drives a req/ack data-memory bus with byte enables. It returns sign- or zero-extended load data to the MEM/WB register and holds the pipeline with `stall_o` until the access completes or times out.

## Interface
- `TIMEOUT`, default 255: BUSY cycles without `dm_ack` before the access is abandoned; legal range 1..1023.
- `Clk  in  1  clock`
- `Rst  in  1  asynchronous, active-low reset`
- `ex_valid  in  1  memory operation presented from EX/MEM`
- `ex_load  in  1  operation is a load`
- `ex_store  in  1  operation is a store; never asserted together with ex_load`
- `ex_funct3  in  3  RV32I width/sign code`
- `ex_addr  in  32  effective byte address (ALU result)`
- `ex_wdata  in  32  rs2 store data`
- `ex_rd  in  5  load destination register`
- `stall_o  out  1  hold IF/ID/EX/MEM pipeline registers`
- `wb_valid  out  1  one-cycle load-complete strobe`
- `wb_rd  out  5  destination register of the completed load`
- `wb_data  out  32  extended load data`
- `err_o  out  1  one-cycle strobe: misaligned/illegal access or bus timeout`
- `dm_req  out  1  bus request; held until ack or timeout`
- `dm_we  out  1  write request`
- `dm_addr  out  32  word-aligned address; bits [1:0] always 0`
- `dm_be  out  4  byte enables`
- `dm_wdata  out  32  lane-replicated store data`
- `dm_ack  in  1  bus completion, sampled on posedge Clk`
- `dm_rdata  in  32  read word, valid when dm_ack=1 and dm_we=0`

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE → BUSY** when `ex_valid & (ex_load | ex_store)` and the access is legal:
  - register addr, be, wdata, funct3, rd and load/store kind;
  - `dm_req` goes high from the next cycle.
- **Illegal access** (misaligned, or funct3 ∈ {011, 110, 111}): IDLE → DONE with the error flag set and no bus request. Misalignment checking is subject to Configuration.
- **BUSY:**
  - `dm_req=1`; `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are stable.
  - On `dm_ack`, go to DONE; for a load, register the extracted `dm_rdata`.
  - The timeout counter increments each BUSY cycle. When it reaches TIMEOUT with no ack, go to DONE with the error flag set.
- **DONE:** lasts one cycle. `stall_o=0` and `ex_valid` is ignored. `wb_valid=1` only for a successful load; `err_o=1` only on error. Then → IDLE.
- **Byte enables:**
  - SB: `0001 << addr[1:0]`.
  - SH: `0011 << {addr[1],1'b0}`.
  - SW: `1111`.
- **Store data:**
  - SB: `{4{b}}`.
  - SH: `{2{h}}`.
  - SW: word unchanged.
- **Load extract:** select the byte or halfword lane by `addr[1:0]`.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- **Stray acks:** `dm_ack` in IDLE or DONE is ignored, including a late ack after a timeout.

## Timing
- `stall_o = (IDLE & ex_valid & (ex_load|ex_store)) | BUSY`; this is combinational.
- Minimum latency with ack in the first BUSY cycle:
  - accept edge T0;
  - BUSY during cycle 1;
  - DONE during cycle 2, when `wb_valid` is high;
  - `stall_o` is high for 2 cycles.
- Each extra wait cycle on `dm_ack` adds one stall cycle.
- Timeout path: `dm_req` is high for exactly TIMEOUT cycles, then one DONE cycle with `err_o=1`.
- Illegal-access path: `stall_o` high 1 cycle, then DONE with `err_o=1`.
- Reset values: state IDLE. `stall_o`, `wb_valid`, `err_o`, `dm_req` and `dm_we` are 0. `wb_rd`, `wb_data`, `dm_addr`, `dm_be`, `dm_wdata` and the counter are 0.
- Reset mid-operation: an asserted Rst forces IDLE and `dm_req=0` immediately (asynchronously), with no completion strobe.
- Back-to-back operations: a new operation is accepted in the IDLE cycle immediately after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`, are illegal.
  - They raise `err_o` with no bus transaction.
- Not defined:
  - low address bits are forced to natural alignment (halfword: clear bit 0; word: clear bits 1:0);
  - the access proceeds normally;
  - `err_o` is raised only for illegal funct3 or timeout.

## Structure
- Package `lsu_pkg`:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010;
  - FSM state typedef (2-bit);
  - the byte-enable generation function.
- Sub-module `load_align`: combinational extraction and sign/zero extension from `{rdata, addr[1:0], funct3}` to the 32-bit result.

## Test plan
- LW at 0x100 with `dm_rdata=0xDEADBEEF`, ack in the first BUSY cycle → `wb_valid` on cycle 2, `wb_data=0xDEADBEEF`, `stall_o` high 2 cycles.
- LB at 0x103 with `dm_rdata=0x80123456` → `wb_data=0xFFFFFF80`; LBU at the same address → `0x00000080`; LHU at 0x102 → `0x00008012`.
- SB of `0x000000A5` to 0x201 → `dm_addr=0x200`, `dm_be=0010`, `dm_wdata=0xA5A5A5A5`, `dm_we=1`, `wb_valid` stays 0.
- SW to 0x302 with `LSU_MISALIGN_TRAP_EN` defined → no `dm_req`, `err_o` pulses once. Without the macro → `dm_addr=0x300`, `dm_be=1111`.
- `dm_ack` held low with TIMEOUT=4 → `dm_req` high exactly 4 cycles, then `err_o` pulse. A later `dm_ack` is ignored and the next LW completes normally.
- Rst asserted during BUSY → `dm_req` and `stall_o` drop immediately. After release, LH at 0x10 completes with correct data.
